// File: rtl/pc_sequencer.sv
// Purpose : instruction-phase sequencer driving the PC input mux (MPC/pc_we) and
//           the memory-request handshake for every PC-, vector- or SP-addressed read.
// Latency : combinational outputs from state; reset release to first ir_ld = 2 cycles,
//           one-word instruction = 3 cycles, taken jump = 2 cycles, +1 per extension word.
// Backpressure: each mem_req holds with stable addr_sel until mem_rdy; the state only
//           advances on that edge, so each transfer produces exactly one strobe.
//
// Optional feature macro: PC_SEQ_IRQ_EN (interrupt vectoring through IRQ_VEC).
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   mem_rdy            memory data valid, completes the current mem_req
//   dec_valid          decoder outputs valid (sampled in DECODE only)
//   dec_ext            extension word count (3 saturates to 2)
//   dec_jump           jump-format instruction
//   jump_taken         jump condition, sampled with dec_valid
//   dec_pc_dst         instruction reloads PC from memory at SP (RET, MOV @SP+,PC)
//   exec_done          execute unit finished (sampled in EXEC only)
//   irq                maskable interrupt pending (used only with PC_SEQ_IRQ_EN)
//   MPC                PC mux select: 0 hold, 1 next_PC, 2 CALC_OUT, 4 MDB_out
//   pc_we              PC register load strobe
//   mem_req            memory read request
//   addr_sel           address source: 0 PC, 1 reset vector, 2 IRQ vector, 3 SP
//   ir_ld, ext_ld      instruction / extension-word register load strobes
//   irq_ack            one-cycle pulse when an interrupt is accepted

module pc_sequencer #(
  parameter logic [1:0] RST_VEC_ADDR_SEL = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_rdy,
  input  logic       dec_valid,
  input  logic [1:0] dec_ext,
  input  logic       dec_jump,
  input  logic       jump_taken,
  input  logic       dec_pc_dst,
  input  logic       exec_done,
  input  logic       irq,
  output logic [2:0] MPC,
  output logic       pc_we,
  output logic       mem_req,
  output logic [1:0] addr_sel,
  output logic       ir_ld,
  output logic       ext_ld,
  output logic       irq_ack
);

  typedef enum logic [2:0] {
    S_RST_VEC = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXT     = 3'd3,
    S_EXEC    = 3'd4,
    S_PC_LOAD = 3'd5,
    S_IRQ_VEC = 3'd6
  } state_t;

  localparam logic [2:0] MPC_HOLD = 3'd0;
  localparam logic [2:0] MPC_NEXT = 3'd1;
  localparam logic [2:0] MPC_CALC = 3'd2;
  localparam logic [2:0] MPC_MDB  = 3'd4;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_IRQ = 2'd2;
  localparam logic [1:0] ADDR_SP  = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] ext_cnt, ext_cnt_nxt;
  logic       pc_dst_q, pc_dst_nxt;

  // Interrupt decision used at every instruction boundary.
  logic take_irq;

`ifdef PC_SEQ_IRQ_EN
  assign take_irq = irq;
`else
  // Port kept for a uniform pinout; interrupts are never taken in this build.
  logic unused_irq;
  assign unused_irq = irq;
  assign take_irq   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST_VEC;
      ext_cnt  <= 2'd0;
      pc_dst_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ext_cnt  <= ext_cnt_nxt;
      pc_dst_q <= pc_dst_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ext_cnt_nxt = ext_cnt;
    pc_dst_nxt  = pc_dst_q;
    MPC         = MPC_HOLD;
    pc_we       = 1'b0;
    mem_req     = 1'b0;
    addr_sel    = ADDR_PC;
    ir_ld       = 1'b0;
    ext_ld      = 1'b0;
    irq_ack     = 1'b0;

    // While rst is high every output stays at its default of 0; the state
    // register is overridden by the reset branch, so next-state is moot.
    if (!rst) begin
      case (state)
        S_RST_VEC: begin
          mem_req  = 1'b1;
          addr_sel = RST_VEC_ADDR_SEL;
          if (mem_rdy) begin
            MPC       = MPC_MDB;
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end
        end

        S_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = ADDR_PC;
          if (mem_rdy) begin
            ir_ld     = 1'b1;
            MPC       = MPC_NEXT;
            pc_we     = 1'b1;
            state_nxt = S_DECODE;
          end
        end

        S_DECODE: begin
          if (dec_valid) begin
            pc_dst_nxt = dec_pc_dst;
            if (dec_jump) begin
              // Jumps finish here: a taken jump loads the computed target,
              // a not-taken jump leaves PC already pointing past the opcode.
              if (jump_taken) begin
                MPC   = MPC_CALC;
                pc_we = 1'b1;
              end
              state_nxt = take_irq ? S_IRQ_VEC : S_FETCH;
              irq_ack   = take_irq;
            end else if (dec_ext != 2'd0) begin
              ext_cnt_nxt = (dec_ext == 2'd3) ? 2'd2 : dec_ext;
              state_nxt   = S_EXT;
            end else begin
              state_nxt = S_EXEC;
            end
          end
        end

        S_EXT: begin
          mem_req  = 1'b1;
          addr_sel = ADDR_PC;
          if (mem_rdy) begin
            ext_ld = 1'b1;
            MPC    = MPC_NEXT;
            pc_we  = 1'b1;
            // A zero count cannot be reached legally; treat it like the last
            // word so the sequencer can never get stuck here.
            if (ext_cnt <= 2'd1) begin
              ext_cnt_nxt = 2'd0;
              state_nxt   = S_EXEC;
            end else begin
              ext_cnt_nxt = ext_cnt - 2'd1;
            end
          end
        end

        S_EXEC: begin
          if (exec_done) begin
            // A pending PC reload from the stack completes before any
            // interrupt so the return address is not lost.
            if (pc_dst_q) begin
              state_nxt = S_PC_LOAD;
            end else begin
              state_nxt = take_irq ? S_IRQ_VEC : S_FETCH;
              irq_ack   = take_irq;
            end
          end
        end

        S_PC_LOAD: begin
          mem_req  = 1'b1;
          addr_sel = ADDR_SP;
          if (mem_rdy) begin
            MPC       = MPC_MDB;
            pc_we     = 1'b1;
            state_nxt = take_irq ? S_IRQ_VEC : S_FETCH;
            irq_ack   = take_irq;
          end
        end

        S_IRQ_VEC: begin
          mem_req  = 1'b1;
          addr_sel = ADDR_IRQ;
          if (mem_rdy) begin
            MPC       = MPC_MDB;
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end
        end

        default: begin
          // Unused encoding: recover through the reset vector.
          state_nxt = S_RST_VEC;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-phase sequencer that drives the 3-bit `MPC` select and write enable of the program-counter input mux. It walks each instruction through fetch, decode, extension-word fetch, execute and optional PC reload, and it handles the reset vector and, optionally, interrupt vectors. It sits between the decoder/execute unit and the PC register. It also owns the memory-request handshake for every PC-addressed access.

## Interface
Parameters:
- `RST_VEC_ADDR_SEL`, 2'd1: `addr_sel` code driven during the reset-vector load.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; **synchronous, active-high**; one clock domain only.
- `mem_rdy`  in  1  memory data on `MDB_out` valid this cycle; completes the current `mem_req`.
- `dec_valid`  in  1  decoder outputs valid for the instruction in IR.
- `dec_ext`  in  2  extension words required (0–2; 3 treated as 2).
- `dec_jump`  in  1  jump-format instruction.
- `jump_taken`  in  1  jump condition true; sampled with `dec_valid`.
- `dec_pc_dst`  in  1  instruction loads PC from memory (RET, MOV @SP+,PC).
- `exec_done`  in  1  execute unit finished the current instruction.
- `irq`  in  1  maskable interrupt pending (only with macro).
- `MPC`  out  3  PC mux select: 0 hold, 1 next_PC, 2 CALC_OUT, 4 MDB_out; 3 is never driven.
- `pc_we`  out  1  PC register load strobe.
- `mem_req`  out  1  memory read request.
- `addr_sel`  out  2  address source: 0 PC, 1 reset vector 0xFFFE, 2 IRQ vector, 3 SP.
- `ir_ld`  out  1  load instruction register from `MDB_out`.
- `ext_ld`  out  1  load extension-word register from `MDB_out`.
- `irq_ack`  out  1  interrupt accepted, one-cycle pulse (only with macro).

## Operation
- States: RST_VEC, FETCH, DECODE, EXT, EXEC, PC_LOAD, IRQ_VEC.
- Output logic is combinational from the state register, `mem_rdy` and the `dec_*` inputs. All outputs are forced to 0 while `rst` is high.
- `MPC` is 0 whenever `pc_we` is 0.
- RST_VEC:
  - `mem_req`=1, `addr_sel`=`RST_VEC_ADDR_SEL`.
  - On `mem_rdy`: `MPC`=4, `pc_we`=1, go to FETCH.
- FETCH:
  - `mem_req`=1, `addr_sel`=0.
  - On `mem_rdy`: `ir_ld`=1, `MPC`=1, `pc_we`=1, go to DECODE.
- DECODE: wait for `dec_valid`. In that cycle, latch `dec_pc_dst` and take the first matching case:
  - Jump taken: `MPC`=2, `pc_we`=1, go to BOUNDARY.
  - Jump not taken: go to BOUNDARY.
  - `dec_ext`≠0: load the 2-bit counter with min(`dec_ext`,2), go to EXT.
  - Otherwise: go to EXEC.
- EXT:
  - `mem_req`=1, `addr_sel`=0.
  - On `mem_rdy`: `ext_ld`=1, `MPC`=1, `pc_we`=1, decrement the counter.
  - When the counter was 1, go to EXEC.
- EXEC: wait for `exec_done`. Then go to PC_LOAD if the latched `dec_pc_dst` is set, else go to BOUNDARY.
- PC_LOAD:
  - `mem_req`=1, `addr_sel`=3.
  - On `mem_rdy`: `MPC`=4, `pc_we`=1, go to BOUNDARY.
- BOUNDARY (a transition rule, not a state): go to IRQ_VEC if `irq` is high in that cycle (macro builds only), else go to FETCH.
- IRQ_VEC:
  - `irq_ack` pulses on the entry transition cycle.
  - State behaviour: `mem_req`=1, `addr_sel`=2.
  - On `mem_rdy`: `MPC`=4, `pc_we`=1, go to FETCH.
- `irq` is sampled only at BOUNDARY. It is ignored during RST_VEC, mid-instruction and in IRQ_VEC.

## Timing
- Reset: `rst` high at any edge puts the block in RST_VEC on the next cycle and clears the counter and the `dec_pc_dst` latch. Reset mid-operation aborts the instruction with no PC write.
- Every `mem_req` holds, with stable `addr_sel`, until the cycle `mem_rdy`=1. The state advances on that edge, so there is exactly one strobe per transfer.
- `mem_rdy` seen outside a memory state is ignored.
- Minimum latencies at `mem_rdy`=1 every cycle:
  - Reset release to first `ir_ld`: 2 cycles.
  - One-word instruction fetch to next fetch: FETCH, DECODE, EXEC = 3 cycles (`dec_valid` and `exec_done` in the first cycle each).
  - Taken jump: FETCH, DECODE = 2 cycles.
  - Each extension word adds 1 cycle.
- `exec_done` and `irq` in the same cycle: IRQ_VEC wins over FETCH. `dec_pc_dst` wins over `irq`; PC_LOAD runs first.
- `dec_valid` and `exec_done` outside their states are ignored.

## Configuration
- `PC_SEQ_IRQ_EN` defined: IRQ_VEC state, `irq` input and `irq_ack` output are present. BOUNDARY checks `irq`.
- Not defined: the ports still exist. `irq` is ignored, `irq_ack` is tied 0, IRQ_VEC is unreachable, and BOUNDARY always goes to FETCH.

## Test plan
- Reset vector: release `rst`, `mem_rdy`=1 with `MDB_out`=0xC000 → cycle 1 `MPC`=4, `pc_we`=1, `addr_sel`=1; cycle 2 `ir_ld`=1, `MPC`=1, `addr_sel`=0.
- Two extension words: `dec_ext`=2 with `mem_rdy` low for 2 cycles on the first word → `mem_req` held 3 cycles, then exactly two `ext_ld`/`pc_we` pulses with `MPC`=1, then EXEC.
- Jumps: `dec_jump`=1, `jump_taken`=1 → one `pc_we` with `MPC`=2, next cycle `mem_req`/`addr_sel`=0. With `jump_taken`=0 → no `pc_we` in DECODE.
- RET: `dec_pc_dst`=1, then `exec_done` → `addr_sel`=3, `mem_rdy` gives `MPC`=4, `pc_we`=1, then FETCH.
- Interrupt (`PC_SEQ_IRQ_EN`): `irq`=1 in the same cycle as `exec_done` → `irq_ack` pulse, `addr_sel`=2, `MPC`=4 load, then FETCH. Without the macro → straight to FETCH, `irq_ack`=0.
- Reset mid-EXT: assert `rst` for 1 cycle while the counter is 1 → all outputs 0 during reset, RST_VEC next, no stale `ext_ld`.
